dev_ram_arbiter: RTL and testbench

Round-robin read arbiter that shares the single ROM/RAM read port of the memory subsystem between several I/O-mapped font/ROM devices: Kanji JIS1, Kanji JIS2 and Hangul/Lascom variants. It sits between the devices' `ram_cs`/`ram_addr` outputs and the SDRAM read channel. It captures each request and serialises the requests onto the memory port, returning data to the originator and stalling the CPU while any request is in flight. A per-request timeout guarantees the CPU is never hung by a missing memory response.

---
 rtl/dev_ram_arbiter_pkg.sv | 15 +
 rtl/dev_ram_arbiter_if.sv | 30 +++
 rtl/dev_ram_arbiter_rr_pick.sv | 33 +++
 rtl/dev_ram_arbiter.sv | 150 +++++++++++++++
 tb/tb_dev_ram_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dev_ram_arbiter_pkg.sv
// Shared types and constants for the font/ROM device read arbiter.
// State encoding, index/address widths and the idle data byte live here.
package dev_ram_arbiter_pkg;

  localparam int ADDR_W = 27;
  localparam int IDX_W  = 3;
  localparam logic [7:0] ARB_IDLE_DATA = 8'hFF;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/dev_ram_arbiter_if.sv
// Requester-side and memory-side bus of the device RAM arbiter.
// The slave modport is the arbiter's view; master is the environment's view.
interface dev_ram_arbiter_if #(
  parameter int NREQ = 3
);
  import dev_ram_arbiter_pkg::*;

  logic [NREQ-1:0]             req_cs;
  logic [NREQ-1:0][ADDR_W-1:0] req_addr;
  logic [NREQ-1:0]             req_done;
  logic [7:0]                  req_data;
  logic                        cpu_wait;
  logic                        overrun;
  logic                        mem_rd;
  logic [ADDR_W-1:0]           mem_addr;
  logic                        mem_ready;
  logic                        mem_valid;
  logic [7:0]                  mem_data;

  modport slave (
    input  req_cs, req_addr, mem_ready, mem_valid, mem_data,
    output req_done, req_data, cpu_wait, overrun, mem_rd, mem_addr
  );

  modport master (
    output req_cs, req_addr, mem_ready, mem_valid, mem_data,
    input  req_done, req_data, cpu_wait, overrun, mem_rd, mem_addr
  );

endinterface

// File: rtl/dev_ram_arbiter_rr_pick.sv
// Combinational round-robin picker: the first pending index after i_last wins.
// Kept free of state so other bus arbiters can reuse it.
module rr_pick
  import dev_ram_arbiter_pkg::*;
#(
  parameter int NREQ = 3
) (
  input  logic [NREQ-1:0]  i_pending,
  input  logic [IDX_W-1:0] i_last,
  output logic [IDX_W-1:0] o_winner,
  output logic             o_valid
);

  int w_dist;
  int w_best;

  // Distance from last+1, modulo NREQ; the smallest distance is the winner.
  always_comb begin
    o_winner = '0;
    o_valid  = 1'b0;
    w_dist   = 0;
    w_best   = NREQ;
    for (int j = 0; j < NREQ; j++) begin
      w_dist = (j + 2 * NREQ - int'(i_last) - 1) % NREQ;
      if (i_pending[j] && (w_dist < w_best)) begin
        w_best   = w_dist;
        o_winner = IDX_W'(j);
        o_valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dev_ram_arbiter.sv
// Round-robin read arbiter sharing one memory read port between NREQ font/ROM
// devices; captures request edges, serialises reads and times out lost responses.
module dev_ram_arbiter
  import dev_ram_arbiter_pkg::*;
#(
  parameter int NREQ    = 3,
  parameter int TIMEOUT = 64
) (
  input logic              clk,
  input logic              reset_n,
  dev_ram_arbiter_if.slave bus
);

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  arb_state_t        r_state;
  logic [IDX_W-1:0]  r_cur;
  logic [IDX_W-1:0]  r_last;
  logic [7:0]        r_cnt;
  logic [NREQ-1:0]   r_req_done;
  logic [7:0]        r_req_data;
  logic              r_mem_rd;
  logic [ADDR_W-1:0] r_mem_addr;
  logic              r_overrun;
  logic [NREQ-1:0]   r_cs_prev;
  logic [NREQ-1:0]   r_pending;
  logic [ADDR_W-1:0] r_addr_q [NREQ];

  logic [NREQ-1:0]   w_edge;
  logic [NREQ-1:0]   w_busy;
  logic [NREQ-1:0]   w_take;
  logic [NREQ-1:0]   w_drop;
  logic [NREQ-1:0]   w_pending_next;
  logic [NREQ-1:0]   w_cur_onehot;
  logic [IDX_W-1:0]  w_winner;
  logic              w_valid;
  logic              w_grant;
  logic [ADDR_W-1:0] w_win_addr;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .i_pending (r_pending),
    .i_last    (r_last),
    .o_winner  (w_winner),
    .o_valid   (w_valid)
  );

  assign w_grant = (r_state == ARB_IDLE) && w_valid;

  // An edge is dropped when that requester already has work queued or in flight.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
    assign w_edge[gi]         = bus.req_cs[gi] & ~r_cs_prev[gi];
    assign w_busy[gi]         = (r_state != ARB_IDLE) && (r_cur == IDX_W'(gi));
    assign w_take[gi]         = w_edge[gi] & ~r_pending[gi] & ~w_busy[gi];
    assign w_drop[gi]         = w_edge[gi] & (r_pending[gi] | w_busy[gi]);
    assign w_cur_onehot[gi]   = (r_cur == IDX_W'(gi));
    assign w_pending_next[gi] = w_take[gi] ? 1'b1 :
                                (w_grant && (w_winner == IDX_W'(gi))) ? 1'b0 :
                                r_pending[gi];

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_addr_q[gi] <= '1;
      end else if (w_take[gi]) begin
        r_addr_q[gi] <= bus.req_addr[gi];
      end
    end
  end

  always_comb begin
    w_win_addr = '1;
    for (int j = 0; j < NREQ; j++) begin
      if (w_winner == IDX_W'(j)) begin
        w_win_addr = r_addr_q[j];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cs_prev <= '0;
      r_pending <= '0;
    end else begin
      r_cs_prev <= bus.req_cs;
      r_pending <= w_pending_next;
    end
  end

  // r_cnt holds the number of cycles elapsed since the memory accepted the read.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ARB_IDLE;
      r_cur      <= '0;
      r_last     <= IDX_W'(NREQ - 1);
      r_cnt      <= '0;
      r_req_done <= '0;
      r_req_data <= ARB_IDLE_DATA;
      r_mem_rd   <= 1'b0;
      r_mem_addr <= '1;
      r_overrun  <= 1'b0;
    end else begin
      r_req_done <= '0;
      if (|w_drop) begin
        r_overrun <= 1'b1;
      end
      case (r_state)
        ARB_IDLE: begin
          if (w_valid) begin
            r_cur      <= w_winner;
            r_last     <= w_winner;
            r_mem_rd   <= 1'b1;
            r_mem_addr <= w_win_addr;
            r_state    <= ARB_ISSUE;
          end
        end
        ARB_ISSUE: begin
          if (bus.mem_ready) begin
            r_mem_rd   <= 1'b0;
            r_mem_addr <= '1;
            r_cnt      <= 8'd1;
            r_state    <= ARB_WAIT;
          end
        end
        ARB_WAIT: begin
          if (bus.mem_valid) begin
            r_req_data <= bus.mem_data;
            r_req_done <= w_cur_onehot;
            r_state    <= ARB_IDLE;
          end else if (r_cnt == TIMEOUT_LAST) begin
            r_req_data <= ARB_IDLE_DATA;
            r_req_done <= w_cur_onehot;
            r_state    <= ARB_IDLE;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: begin
          r_state <= ARB_IDLE;
        end
      endcase
    end
  end

  assign bus.req_done = r_req_done;
  assign bus.req_data = r_req_data;
  assign bus.cpu_wait = (|r_pending) | (r_state != ARB_IDLE);
  assign bus.overrun  = r_overrun;
  assign bus.mem_rd   = r_mem_rd;
  assign bus.mem_addr = r_mem_addr;

endmodule

// File: tb/tb_dev_ram_arbiter.sv
// Randomised self-checking bench for dev_ram_arbiter; the expected grant order
// comes from a round-robin model over the set of requesters that fired.
module tb_dev_ram_arbiter;
  import dev_ram_arbiter_pkg::*;

  localparam int NREQ    = 3;
  localparam int TIMEOUT = 64;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  dev_ram_arbiter_if #(.NREQ(NREQ)) bus();

  dev_ram_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int total = 0;
  int bad   = 0;
  int m_last = NREQ - 1;
  logic [26:0] ones = '1;

  // Memory responder for one read: stall ready, accept, delay, return data.
  task automatic serve(input int rdly, input int vdly, input logic [7:0] d,
                       output logic [26:0] a, output logic [NREQ-1:0] dn,
                       output logic [7:0] dd, output bit steady, output bit to);
    int n = 0;
    to = 1'b0; steady = 1'b1; a = '1; dn = '0; dd = '0;
    while (bus.mem_rd !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (bus.mem_rd !== 1'b1) begin
      to = 1'b1;
      return;
    end
    a = bus.mem_addr;
    repeat (rdly) begin
      @(negedge clk);
      if (bus.mem_rd !== 1'b1 || bus.mem_addr !== a) steady = 1'b0;
    end
    bus.mem_ready = 1'b1;
    @(negedge clk);
    bus.mem_ready = 1'b0;
    repeat (vdly) @(negedge clk);
    bus.mem_valid = 1'b1;
    bus.mem_data  = d;
    @(negedge clk);
    bus.mem_valid = 1'b0;
    dn = bus.req_done;
    dd = bus.req_data;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus.req_cs = '0; bus.req_addr = '0;
    bus.mem_ready = 1'b0; bus.mem_valid = 1'b0; bus.mem_data = '0;
    repeat (3) @(negedge clk);
    total++; if (bus.req_done !== 3'b000) begin bad++; $display("FAIL reset_done got=%b exp=000", bus.req_done); end
    total++; if (bus.req_data !== 8'hFF) begin bad++; $display("FAIL reset_data got=%h exp=ff", bus.req_data); end
    total++; if (bus.mem_rd !== 1'b0) begin bad++; $display("FAIL reset_mem_rd got=%b exp=0", bus.mem_rd); end
    total++; if (bus.mem_addr !== ones) begin bad++; $display("FAIL reset_mem_addr got=%h exp=%h", bus.mem_addr, ones); end
    total++; if ({bus.cpu_wait, bus.overrun} !== 2'b00) begin bad++; $display("FAIL reset_wait_ovr got=%b exp=00", {bus.cpu_wait, bus.overrun}); end
    reset_n = 1'b1;
    m_last = NREQ - 1;
    @(negedge clk);
  endtask

  task automatic test_simultaneous();
    logic [26:0] addr [NREQ];
    logic [26:0] a;
    logic [NREQ-1:0] dn, exp_dn;
    logic [7:0] d, dd;
    bit st, to;
    int order[$];
    int idx;
    for (int round = 0; round < 2; round++) begin
      order.delete();
      for (int i = 0; i < NREQ; i++) begin
        addr[i] = 27'($urandom);
        bus.req_addr[i] = addr[i];
      end
      bus.req_cs = '1;
      @(negedge clk);
      bus.req_cs = '0;
      for (int k = 1; k <= NREQ; k++) order.push_back((m_last + k) % NREQ);
      for (int j = 0; j < NREQ; j++) begin
        idx = order[j];
        d = 8'($urandom);
        serve($urandom_range(2, 0), $urandom_range(3, 0), d, a, dn, dd, st, to);
        exp_dn = NREQ'(1 << idx);
        total++; if (to) begin bad++; $display("FAIL sim_issue_timeout got=no_mem_rd exp=mem_rd"); end
        total++; if (a !== addr[idx]) begin bad++; $display("FAIL sim_addr got=%h exp=%h", a, addr[idx]); end
        total++; if (dn !== exp_dn) begin bad++; $display("FAIL sim_done got=%b exp=%b", dn, exp_dn); end
        total++; if (dd !== d) begin bad++; $display("FAIL sim_data got=%h exp=%h", dd, d); end
        total++; if (bus.cpu_wait !== (j < NREQ - 1)) begin bad++; $display("FAIL sim_cpu_wait got=%b exp=%b", bus.cpu_wait, (j < NREQ - 1)); end
        $display("txn sim round=%0d req=%0d addr=%h data=%h", round, idx, a, dd);
        m_last = idx;
      end
      @(negedge clk);
      total++; if (bus.cpu_wait !== 1'b0) begin bad++; $display("FAIL sim_wait_end got=%b exp=0", bus.cpu_wait); end
    end
  endtask

  task automatic test_single();
    bus.req_addr[1] = 27'h0000123;
    bus.req_cs = 3'b010;
    @(negedge clk);
    bus.req_cs = '0;
    total++; if (bus.cpu_wait !== 1'b1) begin bad++; $display("FAIL single_wait got=%b exp=1", bus.cpu_wait); end
    @(negedge clk);
    total++; if (bus.mem_rd !== 1'b1) begin bad++; $display("FAIL single_mem_rd got=%b exp=1", bus.mem_rd); end
    total++; if (bus.mem_addr !== 27'h0000123) begin bad++; $display("FAIL single_addr got=%h exp=0000123", bus.mem_addr); end
    bus.mem_ready = 1'b1;
    @(negedge clk);
    bus.mem_ready = 1'b0;
    total++; if (bus.req_done !== 3'b000) begin bad++; $display("FAIL single_early_done got=%b exp=000", bus.req_done); end
    bus.mem_valid = 1'b1;
    bus.mem_data  = 8'h5A;
    @(negedge clk);
    bus.mem_valid = 1'b0;
    total++; if (bus.req_done !== 3'b010) begin bad++; $display("FAIL single_done got=%b exp=010", bus.req_done); end
    total++; if (bus.req_data !== 8'h5A) begin bad++; $display("FAIL single_data got=%h exp=5a", bus.req_data); end
    $display("txn single req=1 addr=0000123 data=%h", bus.req_data);
    @(negedge clk);
    total++; if (bus.req_done !== 3'b000) begin bad++; $display("FAIL single_pulse_width got=%b exp=000", bus.req_done); end
    total++; if (bus.req_data !== 8'h5A) begin bad++; $display("FAIL single_data_hold got=%h exp=5a", bus.req_data); end
    m_last = 1;
  endtask

  task automatic test_ready_stall();
    int r = $urandom_range(NREQ - 1, 0);
    logic [26:0] addr = 27'($urandom);
    logic [26:0] a;
    logic [NREQ-1:0] dn;
    logic [7:0] d = 8'($urandom);
    logic [7:0] dd;
    bit st, to;
    bus.req_addr[r] = addr;
    bus.req_cs = NREQ'(1 << r);
    @(negedge clk);
    bus.req_cs = '0;
    serve(10, 1, d, a, dn, dd, st, to);
    total++; if (to) begin bad++; $display("FAIL stall_issue_timeout got=no_mem_rd exp=mem_rd"); end
    total++; if (st !== 1'b1) begin bad++; $display("FAIL stall_steady got=%b exp=1", st); end
    total++; if (a !== addr) begin bad++; $display("FAIL stall_addr got=%h exp=%h", a, addr); end
    total++; if ({dn, dd} !== {NREQ'(1 << r), d}) begin bad++; $display("FAIL stall_done_data got=%b/%h exp=%b/%h", dn, dd, NREQ'(1 << r), d); end
    $display("txn stall req=%0d addr=%h data=%h", r, a, dd);
    m_last = r;
  endtask

  task automatic test_timeout();
    int r = $urandom_range(NREQ - 1, 0);
    int r2 = (r + 1) % NREQ;
    logic [26:0] addr = 27'($urandom);
    logic [26:0] a;
    logic [NREQ-1:0] dn;
    logic [7:0] d = 8'($urandom);
    logic [7:0] dd;
    bit st, to, early;
    int n = 0;
    bus.req_addr[r] = addr;
    bus.req_cs = NREQ'(1 << r);
    @(negedge clk);
    bus.req_cs = '0;
    while (bus.mem_rd !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    total++; if (bus.mem_rd !== 1'b1 || bus.mem_addr !== addr) begin bad++; $display("FAIL to_issue got=%b/%h exp=1/%h", bus.mem_rd, bus.mem_addr, addr); end
    bus.mem_ready = 1'b1;
    @(negedge clk);
    bus.mem_ready = 1'b0;
    early = 1'b0;
    repeat (TIMEOUT - 2) begin
      @(negedge clk);
      if (bus.req_done !== '0) early = 1'b1;
    end
    total++; if (early !== 1'b0) begin bad++; $display("FAIL to_early got=%b exp=0", early); end
    @(negedge clk);
    total++; if (bus.req_done !== NREQ'(1 << r)) begin bad++; $display("FAIL to_done got=%b exp=%b", bus.req_done, NREQ'(1 << r)); end
    total++; if (bus.req_data !== 8'hFF) begin bad++; $display("FAIL to_data got=%h exp=ff", bus.req_data); end
    $display("txn timeout req=%0d addr=%h data=%h", r, addr, bus.req_data);
    m_last = r;
    addr = 27'($urandom);
    bus.req_addr[r2] = addr;
    bus.req_cs = NREQ'(1 << r2);
    @(negedge clk);
    bus.req_cs = '0;
    serve(0, 0, d, a, dn, dd, st, to);
    total++; if ({to, a, dn, dd} !== {1'b0, addr, NREQ'(1 << r2), d}) begin bad++; $display("FAIL to_next got=%b/%h/%b/%h exp=0/%h/%b/%h", to, a, dn, dd, addr, NREQ'(1 << r2), d); end
    $display("txn after_timeout req=%0d addr=%h data=%h", r2, a, dd);
    m_last = r2;
  endtask

  task automatic test_random();
    logic [26:0] addr [NREQ];
    logic [26:0] a;
    logic [NREQ-1:0] dn, exp_dn;
    logic [7:0] d, dd;
    bit st, to;
    int order[$];
    int mask, idx;
    for (int round = 0; round < 12; round++) begin
      order.delete();
      mask = $urandom_range(7, 1);
      for (int i = 0; i < NREQ; i++) begin
        addr[i] = 27'($urandom);
        bus.req_addr[i] = addr[i];
      end
      bus.req_cs = NREQ'(mask);
      @(negedge clk);
      bus.req_cs = '0;
      for (int k = 1; k <= NREQ; k++) begin
        idx = (m_last + k) % NREQ;
        if (mask[idx]) order.push_back(idx);
      end
      foreach (order[j]) begin
        idx = order[j];
        d = 8'($urandom);
        serve($urandom_range(4, 0), $urandom_range(6, 0), d, a, dn, dd, st, to);
        exp_dn = NREQ'(1 << idx);
        total++; if (to) begin bad++; $display("FAIL rnd_issue_timeout got=no_mem_rd exp=mem_rd"); end
        total++; if ({st, a} !== {1'b1, addr[idx]}) begin bad++; $display("FAIL rnd_addr got=%b/%h exp=1/%h", st, a, addr[idx]); end
        total++; if ({dn, dd} !== {exp_dn, d}) begin bad++; $display("FAIL rnd_done_data got=%b/%h exp=%b/%h", dn, dd, exp_dn, d); end
        $display("txn rnd round=%0d req=%0d addr=%h data=%h", round, idx, a, dd);
        m_last = idx;
      end
      @(negedge clk);
    end
    total++; if (bus.overrun !== 1'b0) begin bad++; $display("FAIL rnd_overrun got=%b exp=0", bus.overrun); end
  endtask

  task automatic test_overrun();
    logic [26:0] a0 = 27'($urandom);
    logic [26:0] a1 = 27'($urandom);
    logic [26:0] a;
    logic [NREQ-1:0] dn;
    logic [7:0] d = 8'($urandom);
    logic [7:0] dd;
    bit st, to;
    int extra = 0;
    bus.req_addr[0] = a0;
    bus.req_addr[1] = a1;
    bus.req_cs = 3'b010;
    @(negedge clk);
    bus.req_cs = '0;
    @(negedge clk);
    bus.req_cs = 3'b001;
    @(negedge clk);
    bus.req_cs = '0;
    @(negedge clk);
    total++; if (bus.overrun !== 1'b0) begin bad++; $display("FAIL ovr_before got=%b exp=0", bus.overrun); end
    bus.req_cs = 3'b001;
    @(negedge clk);
    bus.req_cs = '0;
    @(negedge clk);
    total++; if (bus.overrun !== 1'b1) begin bad++; $display("FAIL ovr_set got=%b exp=1", bus.overrun); end
    serve(0, 0, d, a, dn, dd, st, to);
    total++; if ({to, a, dn, dd} !== {1'b0, a1, 3'b010, d}) begin bad++; $display("FAIL ovr_first got=%b/%h/%b/%h exp=0/%h/010/%h", to, a, dn, dd, a1, d); end
    serve(0, 0, ~d, a, dn, dd, st, to);
    total++; if ({to, a, dn, dd} !== {1'b0, a0, 3'b001, ~d}) begin bad++; $display("FAIL ovr_second got=%b/%h/%b/%h exp=0/%h/001/%h", to, a, dn, dd, a0, ~d); end
    $display("txn overrun req=0 addr=%h data=%h", a, dd);
    repeat (8) begin
      @(negedge clk);
      if (bus.req_done !== '0) extra++;
    end
    total++; if (extra !== 0) begin bad++; $display("FAIL ovr_extra_done got=%0d exp=0", extra); end
    total++; if (bus.overrun !== 1'b1) begin bad++; $display("FAIL ovr_sticky got=%b exp=1", bus.overrun); end
    m_last = 0;
  endtask

  task automatic test_reset_mid();
    int n = 0;
    int extra = 0;
    bus.req_addr[2] = 27'($urandom);
    bus.req_cs = 3'b100;
    @(negedge clk);
    bus.req_cs = '0;
    while (bus.mem_rd !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    bus.mem_ready = 1'b1;
    @(negedge clk);
    bus.mem_ready = 1'b0;
    @(negedge clk);
    total++; if (bus.cpu_wait !== 1'b1) begin bad++; $display("FAIL rst_mid_inflight got=%b exp=1", bus.cpu_wait); end
    reset_n = 1'b0;
    #1;
    total++; if ({bus.mem_rd, bus.mem_addr, bus.cpu_wait, bus.overrun} !== {1'b0, ones, 1'b0, 1'b0}) begin bad++; $display("FAIL rst_mid_async got=%b/%h/%b/%b exp=0/%h/0/0", bus.mem_rd, bus.mem_addr, bus.cpu_wait, bus.overrun, ones); end
    @(negedge clk);
    total++; if ({bus.req_done, bus.req_data} !== {3'b000, 8'hFF}) begin bad++; $display("FAIL rst_mid_outputs got=%b/%h exp=000/ff", bus.req_done, bus.req_data); end
    reset_n = 1'b1;
    m_last = NREQ - 1;
    bus.mem_valid = 1'b1;
    bus.mem_data  = 8'h77;
    @(negedge clk);
    bus.mem_valid = 1'b0;
    repeat (5) begin
      if (bus.req_done !== '0) extra++;
      @(negedge clk);
    end
    total++; if (extra !== 0) begin bad++; $display("FAIL rst_mid_late_valid got=%0d exp=0", extra); end
    total++; if ({bus.req_data, bus.mem_addr, bus.cpu_wait} !== {8'hFF, ones, 1'b0}) begin bad++; $display("FAIL rst_mid_after got=%h/%h/%b exp=ff/%h/0", bus.req_data, bus.mem_addr, bus.cpu_wait, ones); end
  endtask

  initial begin
    test_reset();
    test_simultaneous();
    test_single();
    test_ready_stall();
    test_timeout();
    test_random();
    test_overrun();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
